cpack_code_packer: RTL and testbench

//  Downstream of the per-word compressor comparators. Takes one variable-length

---
 rtl/cpack_code_packer.sv | 108 ++++++++++
 tb/tb_cpack_code_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpack_code_packer.sv
// cpack_code_packer: packs variable-length compressed codes MSB-first into
// fixed OUT_W-bit words; flush closes the stream with a zero-padded last word.
module cpack_code_packer #(
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned MAX_CODE_W = 34,
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [MAX_CODE_W-1:0] code_i,
  input  logic [LEN_W-1:0]      code_len_i,
  input  logic                  code_valid_i,
  output logic                  code_ready_o,
  input  logic                  flush_i,
  output logic [OUT_W-1:0]      word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  word_last_o,
  output logic                  flush_done_o,
  output logic [CNT_W-1:0]      bit_count_o
);

  // Worst case: OUT_W-1 bits buffered plus one maximal code.
  localparam int unsigned ACC_W  = OUT_W - 1 + MAX_CODE_W;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]      bits_q, bits_d;

  logic [LEN_W-1:0]      len_c;
  logic [MAX_CODE_W-1:0] code_m;
  logic [ACC_W-1:0]      acc_base;
  logic [ACC_W-1:0]      code_ext;
  logic [FILL_W-1:0]     fill_base;
  logic [FILL_W-1:0]     shamt;
  logic [CNT_W:0]        bits_sum;
  logic                  full;
  logic                  accept;
  logic                  pop;

  // Over-long lengths clamp to the widest legal code; bits above the length are dropped.
  assign len_c  = (code_len_i > LEN_W'(MAX_CODE_W)) ? LEN_W'(MAX_CODE_W) : code_len_i;
  assign code_m = code_i & ~({MAX_CODE_W{1'b1}} << len_c);

  // Accumulator is MSB-aligned and kept zero below fill, so the tail word is
  // already zero-padded when it leaves.
  assign full         = (fill_q >= FILL_W'(OUT_W));
  assign word_o       = acc_q[ACC_W-1 -: OUT_W];
  assign word_valid_o = full | ((state_q == S_FLUSH) && (fill_q != '0));
  assign word_last_o  = (state_q == S_FLUSH) && (fill_q != '0) && (fill_q <= FILL_W'(OUT_W));
  assign flush_done_o = (state_q == S_FLUSH) && (fill_q == '0);
  assign code_ready_o = !rst_i && (state_q == S_RUN) && !full;
  assign bit_count_o  = bits_q;
  assign accept       = code_valid_i & code_ready_o;
  assign pop          = word_valid_o & word_ready_i;

  // Datapath next state: pop first, then append the new code below what remains.
  always_comb begin
    acc_base  = acc_q;
    fill_base = fill_q;
    if (pop) begin
      acc_base  = acc_q << OUT_W;
      fill_base = full ? (fill_q - FILL_W'(OUT_W)) : '0;
    end
    code_ext = ACC_W'(code_m);
    shamt    = FILL_W'(ACC_W) - fill_base - FILL_W'(len_c);
    bits_sum = {1'b0, bits_q} + (CNT_W + 1)'(len_c);
    acc_d    = acc_base;
    fill_d   = fill_base;
    bits_d   = bits_q;
    if (accept) begin
      acc_d  = acc_base | (code_ext << shamt);
      fill_d = fill_base + FILL_W'(len_c);
      bits_d = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
    end
  end

  // Control: enter FLUSH on request, return to RUN once drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush_i) state_d = S_FLUSH;
      S_FLUSH: if (fill_q == '0) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      bits_q  <= bits_d;
    end
  end

endmodule

// File: tb/tb_cpack_code_packer.sv
module tb_cpack_code_packer;
  localparam int MC = 34;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [MC-1:0] code_i;
  logic [5:0]    code_len_i;
  logic          code_valid_i;
  logic          code_ready_o;
  logic          flush_i;
  logic [31:0]   word_o;
  logic          word_valid_o;
  logic          word_ready_i;
  logic          word_last_o;
  logic          flush_done_o;
  logic [31:0]   bit_count_o;

  int          checks = 0;
  int          errors = 0;
  bit          mdl_q[$];
  logic [31:0] got_w[$];
  bit          got_l[$];
  logic [31:0] exp_w[$];
  bit          exp_l[$];
  int          done_cnt = 0;
  int          acc_cnt  = 0;
  int          seg_bits = 0;
  longint      exp_bits = 0;

  cpack_code_packer #(.OUT_W(32), .MAX_CODE_W(34), .LEN_W(6), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .code_i(code_i), .code_len_i(code_len_i),
    .code_valid_i(code_valid_i), .code_ready_o(code_ready_o), .flush_i(flush_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_last_o(word_last_o), .flush_done_o(flush_done_o), .bit_count_o(bit_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // One clock: observe handshakes at negedge, update model, return 1 after posedge.
  task automatic tick();
    int n;
    @(negedge clk_i);
    if (code_valid_i && code_ready_o) begin
      n = (code_len_i > 6'd34) ? 34 : int'(code_len_i);
      for (int i = n - 1; i >= 0; i--) mdl_q.push_back(code_i[i]);
      acc_cnt++;
      seg_bits += n;
      exp_bits += n;
    end
    if (word_valid_o && word_ready_i) begin
      got_w.push_back(word_o);
      got_l.push_back(word_last_o);
    end
    if (flush_done_o) done_cnt++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != start) break;
      word_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
    end
    ok = (done_cnt != start);
  endtask

  // Split the accepted bit stream into 32-bit words, zero-padding the tail.
  task automatic build_exp();
    logic [31:0] w;
    exp_w.delete();
    exp_l.delete();
    while (mdl_q.size() > 0) begin
      w = '0;
      for (int i = 0; i < 32; i++) if (mdl_q.size() > 0) w[31-i] = mdl_q.pop_front();
      exp_w.push_back(w);
      exp_l.push_back(mdl_q.size() == 0);
    end
  endtask

  task automatic start_seg();
    mdl_q.delete();
    got_w.delete();
    got_l.delete();
    seg_bits = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; code_i = '0; code_len_i = '0; code_valid_i = 0; flush_i = 0; word_ready_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (code_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", code_ready_o); end
    checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid_o); end
    checks++; if (word_o !== 32'h0) begin errors++; $display("FAIL reset_word got %h exp 0", word_o); end
    checks++; if (word_last_o !== 1'b0 || flush_done_o !== 1'b0) begin errors++; $display("FAIL reset_last_done got %b%b exp 00", word_last_o, flush_done_o); end
    checks++; if (bit_count_o !== 32'h0) begin errors++; $display("FAIL reset_bits got %0d exp 0", bit_count_o); end
    rst_i = 0;
    #1;
    checks++; if (code_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", code_ready_o); end
    start_seg();
    exp_bits = 0;
  endtask

  task automatic test_example();
    start_seg();
    word_ready_i = 1;
    code_valid_i = 1; code_i = 34'hDAB; code_len_i = 12; tick();
    code_i = {2'b10, 32'h12345678}; code_len_i = 34; tick();
    code_valid_i = 0;
    checks++; if (word_valid_o !== 1'b1 || word_o !== 32'hDAB848D1 || word_last_o !== 1'b0) begin errors++; $display("FAIL ex_word1 got v%b %h l%b exp v1 dab848d1 l0", word_valid_o, word_o, word_last_o); end
    tick();
    checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL ex_fill14_valid got %b exp 0", word_valid_o); end
    flush_i = 1; tick(); flush_i = 0;
    checks++; if (word_valid_o !== 1'b1 || word_o !== 32'h59E00000 || word_last_o !== 1'b1) begin errors++; $display("FAIL ex_tail got v%b %h l%b exp v1 59e00000 l1", word_valid_o, word_o, word_last_o); end
    tick();
    checks++; if (flush_done_o !== 1'b1 || word_valid_o !== 1'b0) begin errors++; $display("FAIL ex_done got d%b v%b exp d1 v0", flush_done_o, word_valid_o); end
    tick();
    checks++; if (flush_done_o !== 1'b0) begin errors++; $display("FAIL ex_done_pulse got %b exp 0", flush_done_o); end
    checks++; if (bit_count_o !== 32'd46) begin errors++; $display("FAIL ex_bits got %0d exp 46", bit_count_o); end
  endtask

  task automatic test_back_to_back();
    start_seg();
    word_ready_i = 1;
    code_valid_i = 1; code_i = '0; code_len_i = 2;
    for (int i = 0; i < 16; i++) begin
      checks++; if (code_ready_o !== 1'b1 || word_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_pre%0d got r%b v%b exp r1 v0", i, code_ready_o, word_valid_o); end
      tick();
    end
    code_valid_i = 0;
    checks++; if (word_valid_o !== 1'b1 || word_o !== 32'h0 || word_last_o !== 1'b0) begin errors++; $display("FAIL b2b_word got v%b %h l%b exp v1 0 l0", word_valid_o, word_o, word_last_o); end
    tick();
    checks++; if (word_valid_o !== 1'b0 || got_w.size() != 1) begin errors++; $display("FAIL b2b_count got v%b n%0d exp v0 n1", word_valid_o, got_w.size()); end
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    logic [MC-1:0] c1;
    bit ok;
    int pre;
    start_seg();
    word_ready_i = 0;
    r = {$urandom, $urandom}; c1 = r[MC-1:0];
    code_valid_i = 1; code_len_i = 34; code_i = c1; tick();
    r = {$urandom, $urandom}; code_i = r[MC-1:0];
    for (int k = 0; k < 4; k++) begin
      checks++; if (word_valid_o !== 1'b1 || word_o !== c1[33:2] || code_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got v%b %h r%b exp v1 %h r0", k, word_valid_o, word_o, code_ready_o, c1[33:2]); end
      tick();
    end
    word_ready_i = 1;
    for (int k = 1; k < 3; k++) begin
      pre = acc_cnt;
      for (int c = 0; c < 10 && acc_cnt == pre; c++) tick();
      checks++; if (acc_cnt == pre) begin errors++; $display("FAIL bp_accept%0d got none exp accepted", k); end
      r = {$urandom, $urandom}; code_i = r[MC-1:0];
    end
    code_valid_i = 0;
    flush_i = 1; tick(); flush_i = 0;
    wait_done(40, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_flush_timeout got none exp flush_done"); end
    build_exp();
    checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL bp_nwords got %0d exp %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL bp_word%0d got %h l%b exp %h l%b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]); end
    end
  endtask

  task automatic test_flush_edges();
    start_seg();
    word_ready_i = 1;
    flush_i = 1; tick(); flush_i = 0;
    checks++; if (flush_done_o !== 1'b1 || word_valid_o !== 1'b0) begin errors++; $display("FAIL fe_empty got d%b v%b exp d1 v0", flush_done_o, word_valid_o); end
    tick();
    checks++; if (flush_done_o !== 1'b0 || got_w.size() != 0) begin errors++; $display("FAIL fe_empty_after got d%b n%0d exp d0 n0", flush_done_o, got_w.size()); end
    code_valid_i = 1; code_i = 34'h3_0000_0A5C; code_len_i = 12; flush_i = 1; tick();
    code_valid_i = 0; flush_i = 0;
    checks++; if (word_valid_o !== 1'b1 || word_o !== 32'hA5C00000 || word_last_o !== 1'b1) begin errors++; $display("FAIL fe_same_cycle got v%b %h l%b exp v1 a5c00000 l1", word_valid_o, word_o, word_last_o); end
    tick();
    checks++; if (flush_done_o !== 1'b1 || got_w.size() != 1) begin errors++; $display("FAIL fe_same_done got d%b n%0d exp d1 n1", flush_done_o, got_w.size()); end
    tick();
  endtask

  task automatic test_len_edges();
    longint b0;
    start_seg();
    b0 = exp_bits;
    word_ready_i = 0;
    code_valid_i = 1; code_i = '1; code_len_i = 0; tick();
    checks++; if (bit_count_o !== 32'(b0) || word_valid_o !== 1'b0) begin errors++; $display("FAIL len0 got bits%0d v%b exp bits%0d v0", bit_count_o, word_valid_o, b0); end
    code_len_i = 40; tick();
    code_valid_i = 0;
    checks++; if (bit_count_o !== 32'(b0 + 34)) begin errors++; $display("FAIL len40_bits got %0d exp %0d", bit_count_o, b0 + 34); end
    checks++; if (word_valid_o !== 1'b1 || word_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL len40_word got v%b %h exp v1 ffffffff", word_valid_o, word_o); end
    word_ready_i = 1; tick();
    checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL len40_fill2 got v%b exp 0", word_valid_o); end
    flush_i = 1; tick(); flush_i = 0;
    checks++; if (word_o !== 32'hC0000000 || word_last_o !== 1'b1) begin errors++; $display("FAIL len40_tail got %h l%b exp c0000000 l1", word_o, word_last_o); end
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [63:0] r;
    bit ok;
    for (int seg = 0; seg < 3; seg++) begin
      start_seg();
      for (int c = 0; c < 250; c++) begin
        r = {$urandom, $urandom};
        code_i = r[MC-1:0];
        code_len_i = 6'($urandom_range(0, 40));
        code_valid_i = ($urandom_range(0, 3) != 0);
        word_ready_i = ($urandom_range(0, 3) != 0);
        tick();
      end
      code_valid_i = ($urandom_range(0, 1) != 0);
      flush_i = 1; tick(); flush_i = 0; code_valid_i = 0;
      wait_done(200, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout got none exp flush_done", seg); end
      build_exp();
      checks++; if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL rnd%0d_nwords got %0d exp %0d", seg, got_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
        checks++; if (got_w[i] !== exp_w[i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h exp %h", seg, i, got_w[i], exp_w[i]); end
        // A final word that is exactly full may leave before the flush and carry last=0.
        if (i != exp_w.size() - 1 || (seg_bits % 32) != 0) begin
          checks++; if (got_l[i] !== exp_l[i]) begin errors++; $display("FAIL rnd%0d_last%0d got %b exp %b", seg, i, got_l[i], exp_l[i]); end
        end
      end
      checks++; if (bit_count_o !== 32'(exp_bits)) begin errors++; $display("FAIL rnd%0d_bits got %0d exp %0d", seg, bit_count_o, exp_bits); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_seg();
    word_ready_i = 0;
    code_valid_i = 1; code_i = 34'hF_ABCD; code_len_i = 20; flush_i = 1; tick();
    code_valid_i = 0; flush_i = 0;
    checks++; if (word_valid_o !== 1'b1 || word_o !== 32'hFABCD000) begin errors++; $display("FAIL rm_pre got v%b %h exp v1 fabcd000", word_valid_o, word_o); end
    #2 rst_i = 1;
    #1;
    checks++; if (word_valid_o !== 1'b0 || word_o !== 32'h0 || word_last_o !== 1'b0 || flush_done_o !== 1'b0 || code_ready_o !== 1'b0 || bit_count_o !== 32'h0) begin errors++; $display("FAIL rm_async got v%b %h l%b d%b r%b b%0d exp all 0", word_valid_o, word_o, word_last_o, flush_done_o, code_ready_o, bit_count_o); end
    @(posedge clk_i); #1;
    rst_i = 0;
    start_seg();
    exp_bits = 0;
    word_ready_i = 1;
    code_valid_i = 1; code_i = 34'hABC; code_len_i = 12; flush_i = 1; tick();
    code_valid_i = 0; flush_i = 0;
    checks++; if (word_o !== 32'hABC00000 || word_last_o !== 1'b1 || bit_count_o !== 32'd12) begin errors++; $display("FAIL rm_fresh got %h l%b b%0d exp abc00000 l1 b12", word_o, word_last_o, bit_count_o); end
    wait_done(10, 1'b0, ok);
    checks++; if (!ok || got_w.size() != 1) begin errors++; $display("FAIL rm_done got ok%b n%0d exp ok1 n1", ok, got_w.size()); end
  endtask

  initial begin
    test_reset();
    test_example();
    test_back_to_back();
    test_backpressure();
    test_flush_edges();
    test_len_edges();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
